inst_fetch_unit: RTL

Multi-cycle instruction fetch stage that owns the program counter and fetches 32-bit instructions over a request/grant/response memory bus. It sits directly upstream of the core's decode/execute datapath and replaces the combinational instruction-memory lookup with a latency-tolerant handshake. The core consumes one held instruction per `advance` pulse and steers the next fetch with the branch/jump target or with a flush.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/adder.sv | 12 +
 rtl/inst_fetch_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_REQ,
      ST_WAIT,
      ST_HOLD
   } fetch_state_e;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam logic [31:0] PC_STEP  = 32'd4;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/adder.sv
// Plain modulo adder used for sequential PC increment.
module adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/inst_fetch_unit.sv
// Multi-cycle fetch stage: owns the PC and fetches one instruction at a time
// over a request/grant/response bus, holding it until the core advances.
module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        advance,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic [31:0] pc_out,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic        fetch_err,
   output logic        misalign_err,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic        mem_err
);

   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  pc_out_q, pc_out_d;
   logic [31:0]  inst_q, inst_d;
   logic         inst_valid_q, inst_valid_d;
   logic         fetch_err_q, fetch_err_d;
   logic         misalign_err_q, misalign_err_d;
   logic         discard_q, discard_d;
   logic         mem_req_q, mem_req_d;
   logic [31:0]  mem_addr_q, mem_addr_d;
   logic [31:0]  pc_plus4;
   logic [31:0]  flush_tgt;
   logic [31:0]  next_pc;

   adder #(.WIDTH(32)) u_pc_inc (
      .a   (pc_out_q),
      .b   (PC_STEP),
      .sum (pc_plus4)
   );

   assign flush_tgt = align_pc(flush_pc);
   assign next_pc   = redirect ? align_pc(redirect_pc) : pc_plus4;

   always_comb begin
      state_d        = state_q;
      fetch_pc_d     = fetch_pc_q;
      pc_out_d       = pc_out_q;
      inst_d         = inst_q;
      inst_valid_d   = inst_valid_q;
      fetch_err_d    = fetch_err_q;
      misalign_err_d = misalign_err_q;
      discard_d      = discard_q;
      mem_req_d      = mem_req_q;
      mem_addr_d     = mem_addr_q;

      if (flush) begin
         fetch_pc_d   = flush_tgt;
         inst_valid_d = 1'b0;
         inst_d       = NOP_INST;
         fetch_err_d  = 1'b0;
         if (flush_pc[1:0] != 2'b00) begin
            misalign_err_d = 1'b1;
         end
      end

      unique case (state_q)
         ST_REQ: begin
            mem_req_d = 1'b1;
            // A request already on the bus keeps its address; its response is dropped later.
            if (flush) begin
               if (mem_req_q) begin
                  discard_d = 1'b1;
               end else begin
                  mem_addr_d = flush_tgt;
               end
            end
            if (mem_req_q && mem_gnt) begin
               state_d   = ST_WAIT;
               mem_req_d = 1'b0;
            end
         end

         ST_WAIT: begin
            if (mem_rvalid) begin
               if (discard_q || flush) begin
                  discard_d  = 1'b0;
                  state_d    = ST_REQ;
                  mem_req_d  = 1'b1;
                  mem_addr_d = fetch_pc_d;
               end else begin
                  inst_d       = mem_rdata;
                  fetch_err_d  = mem_err;
                  inst_valid_d = 1'b1;
                  pc_out_d     = fetch_pc_q;
                  state_d      = ST_HOLD;
               end
            end else if (flush) begin
               discard_d = 1'b1;
            end
         end

         ST_HOLD: begin
            if (flush) begin
               state_d    = ST_REQ;
               mem_req_d  = 1'b1;
               mem_addr_d = flush_tgt;
            end else if (advance) begin
               fetch_pc_d   = next_pc;
               mem_addr_d   = next_pc;
               inst_valid_d = 1'b0;
               inst_d       = NOP_INST;
               fetch_err_d  = 1'b0;
               mem_req_d    = 1'b1;
               state_d      = ST_REQ;
               if (redirect && (redirect_pc[1:0] != 2'b00)) begin
                  misalign_err_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_REQ;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_REQ;
         fetch_pc_q     <= RESET_PC;
         pc_out_q       <= RESET_PC;
         inst_q         <= NOP_INST;
         inst_valid_q   <= 1'b0;
         fetch_err_q    <= 1'b0;
         misalign_err_q <= 1'b0;
         discard_q      <= 1'b0;
         mem_req_q      <= 1'b0;
         mem_addr_q     <= RESET_PC;
      end else begin
         state_q        <= state_d;
         fetch_pc_q     <= fetch_pc_d;
         pc_out_q       <= pc_out_d;
         inst_q         <= inst_d;
         inst_valid_q   <= inst_valid_d;
         fetch_err_q    <= fetch_err_d;
         misalign_err_q <= misalign_err_d;
         discard_q      <= discard_d;
         mem_req_q      <= mem_req_d;
         mem_addr_q     <= mem_addr_d;
      end
   end

   assign pc_out       = pc_out_q;
   assign inst         = inst_q;
   assign inst_valid   = inst_valid_q;
   assign fetch_err    = fetch_err_q;
   assign misalign_err = misalign_err_q;
   assign mem_req      = mem_req_q;
   assign mem_addr     = mem_addr_q;

endmodule
